// File: rtl/prefetch_fifo.sv
// prefetch_fifo: entry buffer between the prefetch (line-to-entry) stage and
// the fetch stage. Entries are 68 bits {code[3:0], bytes[63:0]}; code 1..8 is
// a valid byte count, code >= 14 marks a fault. The head entry is presented
// first-word-fall-through on the accept port. A fault entry blocks further
// writes and is never popped; only pr_reset (or rst) clears it.
//
// Optional feature: define PREFETCH_FIFO_BYPASS_EN to let a write into an
// empty FIFO appear on the accept port in the same cycle (and be consumed
// without storage when popped at once). Default build: registered path only.
module prefetch_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pr_reset,
  input  logic              prefetchfifo_write_do,
  input  logic [67:0]       prefetchfifo_write_data,
  output logic              prefetchfifo_full,
  output logic [ADDR_W:0]   prefetchfifo_used,
  input  logic              prefetchfifo_accept_do,
  output logic [67:0]       prefetchfifo_accept_data,
  output logic              prefetchfifo_accept_empty
);

  localparam logic [3:0] PREFETCH_PF_FAULT  = 4'd14;
  localparam logic [3:0] PREFETCH_GP_FAULT  = 4'd15;
  localparam logic [3:0] PREFETCH_MIN_FAULT = 4'd14;
  localparam logic [ADDR_W:0] DEPTH_CNT     = (ADDR_W + 1)'(DEPTH);

  // Storage holds no reset: contents are don't-care whenever count is zero.
  logic [67:0]       mem_reg [DEPTH];

  logic [ADDR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [ADDR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [ADDR_W:0]   count_reg, count_next;
  logic              fault_latched_reg, fault_latched_next;

  logic              stored_empty;
  logic              full;
  logic [67:0]       head_data;
  logic [3:0]        head_code;
  logic [3:0]        write_code;
  logic              write_ok;
  logic              pop_ok;
  logic              store_en;
  logic              bypass_active;
  logic              bypass_consume;

  assign stored_empty = (count_reg == '0);
  assign full         = (count_reg == DEPTH_CNT);
  assign head_data    = mem_reg[rd_ptr_reg];
  assign head_code    = head_data[67:64];
  assign write_code   = prefetchfifo_write_data[67:64];

  // Fault codes are only ever compared against the minimum; the named pair
  // documents the two flavours a producer can send.
  logic unused_fault_codes;
  assign unused_fault_codes = ^{PREFETCH_PF_FAULT, PREFETCH_GP_FAULT};

  // Write acceptance: full is judged on the registered count, so a pop in the
  // same cycle does not make room for a write.
  assign write_ok = prefetchfifo_write_do && !full && !fault_latched_reg &&
                    !pr_reset && (write_code != 4'd0);

  // Pop acceptance: a fault entry at the head is pinned until a flush.
  assign pop_ok = prefetchfifo_accept_do && !stored_empty &&
                  (head_code < PREFETCH_MIN_FAULT) && !pr_reset;

`ifdef PREFETCH_FIFO_BYPASS_EN
  // A write into an empty FIFO is visible on the accept port immediately; a
  // non-fault entry popped in that same cycle never touches storage.
  assign bypass_active  = stored_empty && write_ok;
  assign bypass_consume = bypass_active && prefetchfifo_accept_do &&
                          (write_code < PREFETCH_MIN_FAULT);
`else
  assign bypass_active  = 1'b0;
  assign bypass_consume = 1'b0;
`endif

  assign store_en = write_ok && !bypass_consume;

  // Next-state for pointers, occupancy and the fault latch; flush wins.
  always_comb begin
    rd_ptr_next        = rd_ptr_reg;
    wr_ptr_next        = wr_ptr_reg;
    count_next         = count_reg;
    fault_latched_next = fault_latched_reg;
    if (pr_reset) begin
      rd_ptr_next        = '0;
      wr_ptr_next        = '0;
      count_next         = '0;
      fault_latched_next = 1'b0;
    end else begin
      if (store_en) begin
        wr_ptr_next = wr_ptr_reg + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_next = rd_ptr_reg + 1'b1;
      end
      if (write_ok && (write_code >= PREFETCH_MIN_FAULT)) begin
        fault_latched_next = 1'b1;
      end
      case ({store_en, pop_ok})
        2'b10:   count_next = count_reg + 1'b1;
        2'b01:   count_next = count_reg - 1'b1;
        default: count_next = count_reg;
      endcase
    end
  end

  // Control state register with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_reg        <= '0;
      wr_ptr_reg        <= '0;
      count_reg         <= '0;
      fault_latched_reg <= 1'b0;
    end else begin
      rd_ptr_reg        <= rd_ptr_next;
      wr_ptr_reg        <= wr_ptr_next;
      count_reg         <= count_next;
      fault_latched_reg <= fault_latched_next;
    end
  end

  // Entry storage write port.
  always_ff @(posedge clk) begin
    if (store_en) begin
      mem_reg[wr_ptr_reg] <= prefetchfifo_write_data;
    end
  end

  // Accept port: head entry when something is stored, bypassed write when the
  // FIFO is empty and the bypass path is built in, otherwise zero.
  always_comb begin
    prefetchfifo_accept_data  = 68'd0;
    prefetchfifo_accept_empty = 1'b1;
    if (!stored_empty) begin
      prefetchfifo_accept_data  = head_data;
      prefetchfifo_accept_empty = 1'b0;
    end else if (bypass_active) begin
      prefetchfifo_accept_data  = prefetchfifo_write_data;
      prefetchfifo_accept_empty = 1'b0;
    end
  end

  assign prefetchfifo_full = full;
  assign prefetchfifo_used = count_reg;

endmodule

// File: tb/tb_prefetch_fifo.sv
// Directed bench for prefetch_fifo: reset, fill/drain order, fault blocking,
// flush priority, full-with-pop, and the same-cycle write/accept case (whose
// expectation depends on whether PREFETCH_FIFO_BYPASS_EN is defined).
module tb_prefetch_fifo;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pr_reset = 1'b0;
  logic        wr_do = 1'b0;
  logic [67:0] wr_data = 68'd0;
  logic        full;
  logic [4:0]  used;
  logic        acc_do = 1'b0;
  logic [67:0] acc_data;
  logic        acc_empty;

  int tests = 0;
  int fails = 0;

  prefetch_fifo #(.DEPTH(16), .ADDR_W(4)) dut (
    .clk                       (clk),
    .rst                       (rst),
    .pr_reset                  (pr_reset),
    .prefetchfifo_write_do     (wr_do),
    .prefetchfifo_write_data   (wr_data),
    .prefetchfifo_full         (full),
    .prefetchfifo_used         (used),
    .prefetchfifo_accept_do    (acc_do),
    .prefetchfifo_accept_data  (acc_data),
    .prefetchfifo_accept_empty (acc_empty)
  );

  always #5 clk = ~clk;

  function automatic logic [67:0] mk(input logic [3:0] code, input logic [63:0] bytes);
    return {code, bytes};
  endfunction

  task automatic check(input string tag, input logic [67:0] obs, input logic [67:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("[TB] check %-18s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Advance one clock; inputs are changed and outputs sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    step();
    step();
    check("rst_empty", 68'(acc_empty), 68'd1);
    check("rst_full", 68'(full), 68'd0);
    check("rst_used", 68'(used), 68'd0);
    check("rst_data", acc_data, 68'd0);
    rst = 1'b0;
    step();

    // Async reset mid-stream at count 5
    wr_do = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wr_data = mk(4'd8, 64'h500 + 64'(i));
      step();
    end
    wr_do = 1'b0;
    check("mid_used5", 68'(used), 68'd5);
    rst = 1'b1;
    #1;
    check("mid_rst_used", 68'(used), 68'd0);
    step();
    rst = 1'b0;
    check("mid_rst_empty", 68'(acc_empty), 68'd1);
    check("mid_rst_used2", 68'(used), 68'd0);
    check("mid_rst_data", acc_data, 68'd0);

    // Fill to 16, 17th write dropped, drain in order
    wr_do = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wr_data = mk(4'd8, 64'h1000 + 64'(i));
      step();
    end
    check("fill_full", 68'(full), 68'd1);
    check("fill_used", 68'(used), 68'd16);
    wr_data = mk(4'd8, 64'hDEAD);
    step();
    wr_do = 1'b0;
    check("over_used", 68'(used), 68'd16);
    check("over_head", acc_data, mk(4'd8, 64'h1000));
    acc_do = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("drain_data", acc_data, mk(4'd8, 64'h1000 + 64'(i)));
      step();
    end
    acc_do = 1'b0;
    check("drain_empty", 68'(acc_empty), 68'd1);
    check("drain_used", 68'(used), 68'd0);
    check("drain_data0", acc_data, 68'd0);

    // Fault entry blocks writes and pops
    wr_do = 1'b1;
    wr_data = mk(4'd4, 64'hA4);
    step();
    wr_data = mk(4'd15, 64'hBF);
    step();
    wr_data = mk(4'd8, 64'hC8);
    step();
    wr_do = 1'b0;
    check("fault_used", 68'(used), 68'd2);
    check("fault_head0", acc_data, mk(4'd4, 64'hA4));
    acc_do = 1'b1;
    step();
    check("fault_pop_used", 68'(used), 68'd1);
    check("fault_head", acc_data, mk(4'd15, 64'hBF));
    step();
    step();
    check("fault_hold_used", 68'(used), 68'd1);
    check("fault_hold_head", acc_data, mk(4'd15, 64'hBF));
    acc_do = 1'b0;
    pr_reset = 1'b1;
    step();
    pr_reset = 1'b0;
    check("flush_empty", 68'(acc_empty), 68'd1);
    check("flush_used", 68'(used), 68'd0);
    wr_do = 1'b1;
    wr_data = mk(4'd8, 64'hD8);
    step();
    wr_do = 1'b0;
    check("post_flush_used", 68'(used), 68'd1);
    check("post_flush_head", acc_data, mk(4'd8, 64'hD8));
    // Code 0 is never stored
    wr_do = 1'b1;
    wr_data = mk(4'd0, 64'hE0);
    step();
    wr_do = 1'b0;
    check("code0_used", 68'(used), 68'd1);
    pr_reset = 1'b1;
    step();
    pr_reset = 1'b0;

    // Full with simultaneous write and pop: pop only
    wr_do = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wr_data = mk(4'd3, 64'h2000 + 64'(i));
      step();
    end
    wr_data = mk(4'd3, 64'h2099);
    acc_do = 1'b1;
    step();
    wr_do = 1'b0;
    acc_do = 1'b0;
    check("fullwp_used", 68'(used), 68'd15);
    check("fullwp_full", 68'(full), 68'd0);
    check("fullwp_head", acc_data, mk(4'd3, 64'h2001));
    pr_reset = 1'b1;
    step();
    pr_reset = 1'b0;

    // Flush with write and pop at used 3
    wr_do = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wr_data = mk(4'd2, 64'h300 + 64'(i));
      step();
    end
    check("pre_flush_used", 68'(used), 68'd3);
    wr_data = mk(4'd2, 64'h3FF);
    acc_do = 1'b1;
    pr_reset = 1'b1;
    step();
    wr_do = 1'b0;
    acc_do = 1'b0;
    pr_reset = 1'b0;
    check("flushwp_used", 68'(used), 68'd0);
    check("flushwp_empty", 68'(acc_empty), 68'd1);
    step();
    check("flushwp_used2", 68'(used), 68'd0);

    // Write code 6 and accept in the same cycle while empty
    wr_do = 1'b1;
    acc_do = 1'b1;
    wr_data = mk(4'd6, 64'h66);
    #1;
`ifdef PREFETCH_FIFO_BYPASS_EN
    check("byp_data", acc_data, mk(4'd6, 64'h66));
    check("byp_empty", 68'(acc_empty), 68'd0);
    step();
    wr_do = 1'b0;
    acc_do = 1'b0;
    check("byp_next_empty", 68'(acc_empty), 68'd1);
    check("byp_next_used", 68'(used), 68'd0);
`else
    check("nobyp_empty", 68'(acc_empty), 68'd1);
    check("nobyp_data", acc_data, 68'd0);
    step();
    wr_do = 1'b0;
    acc_do = 1'b0;
    check("nobyp_next_used", 68'(used), 68'd1);
    check("nobyp_next_head", acc_data, mk(4'd6, 64'h66));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
